// File: rtl/sdram_sched_pkg.sv
// Shared types and constants for the three-requester SDRAM port scheduler.
package sdram_sched_pkg;

   // Scheduler FSM states
   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      GRANT     = 2'd1,
      WAIT_DONE = 2'd2,
      RELEASE   = 2'd3
   } state_e;

   // Requester identities; the value doubles as the bit index of its done pulse
   typedef enum logic [1:0] {
      RD = 2'd0,
      W0 = 2'd1,
      W1 = 2'd2
   } req_id_e;

   // Level request encodings towards the base controller
   localparam logic [1:0] CALL_NONE = 2'b00;
   localparam logic [1:0] CALL_RD   = 2'b01;
   localparam logic [1:0] CALL_WR   = 2'b10;

   // Bank(2) + row(13) + column(9) addressing, 16-bit data bus
   localparam int DEFAULT_AW = 24;
   localparam int DEFAULT_DW = 16;

endpackage

// File: rtl/sdram_port_scheduler_if.sv
// Bundle of requester-side and base-controller-side signals of the scheduler.
// The slave modport is the scheduler's view; master is the surrounding system.
interface sdram_port_scheduler_if
   import sdram_sched_pkg::*;
#(
   parameter int AW = DEFAULT_AW,
   parameter int DW = DEFAULT_DW
);
   logic          rd_req;
   logic [AW-1:0] rd_addr;
   logic          rd_done;
   logic [DW-1:0] rd_data;

   logic          w0_req;
   logic [AW-1:0] w0_addr;
   logic [DW-1:0] w0_data;
   logic          w0_done;

   logic          w1_req;
   logic [AW-1:0] w1_addr;
   logic [DW-1:0] w1_data;
   logic          w1_done;

   logic [1:0]    mem_call;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [1:0]    mem_done;
   logic [DW-1:0] mem_rdata;

   logic          busy;
   logic          err_timeout;

   logic [31:0]   stat_rd;
   logic [31:0]   stat_w0;
   logic [31:0]   stat_w1;
   logic [15:0]   stat_timeouts;

   modport slave (
      input  rd_req, rd_addr, w0_req, w0_addr, w0_data,
      input  w1_req, w1_addr, w1_data, mem_done, mem_rdata,
      output rd_done, rd_data, w0_done, w1_done,
      output mem_call, mem_addr, mem_wdata, busy, err_timeout,
      output stat_rd, stat_w0, stat_w1, stat_timeouts
   );

   modport master (
      output rd_req, rd_addr, w0_req, w0_addr, w0_data,
      output w1_req, w1_addr, w1_data, mem_done, mem_rdata,
      input  rd_done, rd_data, w0_done, w1_done,
      input  mem_call, mem_addr, mem_wdata, busy, err_timeout,
      input  stat_rd, stat_w0, stat_w1, stat_timeouts
   );

endinterface

// File: rtl/sdram_port_scheduler_select.sv
// Winner selection: RD has fixed priority unless writes have been starved for
// STARVE_LIMIT consecutive RD grants; W0/W1 alternate through a round-robin pointer.
module sdram_sched_select
   import sdram_sched_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic    clk,
   input  logic    rst,
   input  logic    rd_req,
   input  logic    w0_req,
   input  logic    w1_req,
   input  logic    grant,
   output logic    valid,
   output req_id_e winner
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic [3:0] starve_cnt;
   req_id_e    rr_ptr;
   req_id_e    wr_pick;
   logic       wr_pend;

   // Combinational choice of the next requester from the current request levels
   always_comb begin
      wr_pend = w0_req | w1_req;
      if (w0_req && w1_req) begin
         wr_pick = rr_ptr;
      end else if (w0_req) begin
         wr_pick = W0;
      end else begin
         wr_pick = W1;
      end
      valid = rd_req | wr_pend;
      if (wr_pend && starve_cnt == LIMIT) begin
         winner = wr_pick;
      end else if (rd_req) begin
         winner = RD;
      end else begin
         winner = wr_pick;
      end
   end

   // Starvation count and round-robin pointer advance only when a grant is taken
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt <= '0;
         rr_ptr     <= W0;
      end else if (grant) begin
         if (winner == RD) begin
            if (wr_pend) begin
               if (starve_cnt != LIMIT) begin
                  starve_cnt <= starve_cnt + 1'b1;
               end
            end else begin
               starve_cnt <= '0;
            end
         end else begin
            starve_cnt <= '0;
            rr_ptr     <= (winner == W0) ? W1 : W0;
         end
      end
   end

endmodule

// File: rtl/sdram_port_scheduler.sv
// Shares the single-port SDRAM base controller between the TFT reader (RD),
// the draw writer (W0) and the pulse-log writer (W1).
// Optional statistics counters are built when SDRAM_SCHED_STATS_EN is defined;
// otherwise the stat_* outputs are tied to zero.
module sdram_port_scheduler
   import sdram_sched_pkg::*;
#(
   parameter int STARVE_LIMIT = 4,
   parameter int TIMEOUT_CYC  = 1024,
   parameter int AW           = DEFAULT_AW,
   parameter int DW           = DEFAULT_DW
) (
   input logic clk,
   input logic rst,
   sdram_port_scheduler_if.slave bus
);

   localparam int WDW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYC - 1);

   localparam logic [1:0] ST_IDLE    = 2'(IDLE);
   localparam logic [1:0] ST_GRANT   = 2'(GRANT);
   localparam logic [1:0] ST_WAIT    = 2'(WAIT_DONE);
   localparam logic [1:0] ST_RELEASE = 2'(RELEASE);

   logic [1:0]     state;
   req_id_e        gnt_id;
   logic [AW-1:0]  addr_q;
   logic [DW-1:0]  wdata_q;
   logic [DW-1:0]  rd_data_q;
   logic [1:0]     call_q;
   logic [2:0]     done_q;
   logic [2:0]     blocked;
   logic [WDW-1:0] wd_cnt;
   logic           err_q;

   logic           rd_eff;
   logic           w0_eff;
   logic           w1_eff;
   logic           sel_valid;
   req_id_e        sel_id;
   logic           grant;
   logic           hit;
   logic           abort;

   // A requester whose access was aborted is masked until it drops its request
   assign rd_eff = bus.rd_req & ~blocked[0];
   assign w0_eff = bus.w0_req & ~blocked[1];
   assign w1_eff = bus.w1_req & ~blocked[2];
   assign grant  = (state == ST_IDLE) && sel_valid;

   sdram_sched_select #(
      .STARVE_LIMIT(STARVE_LIMIT)
   ) u_select (
      .clk    (clk),
      .rst    (rst),
      .rd_req (rd_eff),
      .w0_req (w0_eff),
      .w1_req (w1_eff),
      .grant  (grant),
      .valid  (sel_valid),
      .winner (sel_id)
   );

   // Completion (matching done bit only) and watchdog expiry while waiting
   always_comb begin
      hit   = 1'b0;
      abort = 1'b0;
      if (state == ST_WAIT) begin
         hit   = (gnt_id == RD) ? bus.mem_done[0] : bus.mem_done[1];
         abort = !hit && (wd_cnt == WD_LAST);
      end
   end

   // Main access FSM with the datapath registers that feed the base controller
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         gnt_id    <= RD;
         addr_q    <= '0;
         wdata_q   <= '0;
         rd_data_q <= '0;
         call_q    <= CALL_NONE;
         done_q    <= '0;
         wd_cnt    <= '0;
         err_q     <= 1'b0;
      end else begin
         done_q <= '0;
         case (state)
            ST_IDLE: begin
               if (sel_valid) begin
                  gnt_id <= sel_id;
                  case (sel_id)
                     W0: begin
                        addr_q  <= bus.w0_addr;
                        wdata_q <= bus.w0_data;
                     end
                     W1: begin
                        addr_q  <= bus.w1_addr;
                        wdata_q <= bus.w1_data;
                     end
                     default: begin
                        addr_q  <= bus.rd_addr;
                        wdata_q <= '0;
                     end
                  endcase
                  state <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               call_q <= (gnt_id == RD) ? CALL_RD : CALL_WR;
               wd_cnt <= '0;
               state  <= ST_WAIT;
            end
            ST_WAIT: begin
               if (hit) begin
                  call_q <= CALL_NONE;
                  if (gnt_id == RD) begin
                     rd_data_q <= bus.mem_rdata;
                  end
                  done_q <= 3'b001 << gnt_id;
                  state  <= ST_RELEASE;
               end else begin
                  wd_cnt <= wd_cnt + 1'b1;
                  if (abort) begin
                     call_q <= CALL_NONE;
                     err_q  <= 1'b1;
                     state  <= ST_RELEASE;
                  end
               end
            end
            ST_RELEASE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Mask bookkeeping: set on abort, cleared once the requester lets go of req
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         blocked <= '0;
      end else begin
         blocked <= blocked & {bus.w1_req, bus.w0_req, bus.rd_req};
         if (abort) begin
            blocked[gnt_id] <= 1'b1;
         end
      end
   end

   assign bus.rd_done     = done_q[0];
   assign bus.w0_done     = done_q[1];
   assign bus.w1_done     = done_q[2];
   assign bus.rd_data     = rd_data_q;
   assign bus.mem_call    = call_q;
   assign bus.mem_addr    = addr_q;
   assign bus.mem_wdata   = wdata_q;
   assign bus.busy        = (state != ST_IDLE);
   assign bus.err_timeout = err_q;

`ifdef SDRAM_SCHED_STATS_EN
   logic [31:0] stat_rd_q;
   logic [31:0] stat_w0_q;
   logic [31:0] stat_w1_q;
   logic [15:0] stat_to_q;

   // Saturating per-requester completion counts and watchdog abort count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_rd_q <= '0;
         stat_w0_q <= '0;
         stat_w1_q <= '0;
         stat_to_q <= '0;
      end else begin
         if (state == ST_RELEASE && done_q[0] && stat_rd_q != '1) begin
            stat_rd_q <= stat_rd_q + 1'b1;
         end
         if (state == ST_RELEASE && done_q[1] && stat_w0_q != '1) begin
            stat_w0_q <= stat_w0_q + 1'b1;
         end
         if (state == ST_RELEASE && done_q[2] && stat_w1_q != '1) begin
            stat_w1_q <= stat_w1_q + 1'b1;
         end
         if (abort && stat_to_q != '1) begin
            stat_to_q <= stat_to_q + 1'b1;
         end
      end
   end

   assign bus.stat_rd       = stat_rd_q;
   assign bus.stat_w0       = stat_w0_q;
   assign bus.stat_w1       = stat_w1_q;
   assign bus.stat_timeouts = stat_to_q;
`else
   assign bus.stat_rd       = '0;
   assign bus.stat_w0       = '0;
   assign bus.stat_w1       = '0;
   assign bus.stat_timeouts = '0;
`endif

endmodule

// File: tb/tb_sdram_port_scheduler.sv
// Self-checking bench for sdram_port_scheduler: arbitration order from a vector
// table, plus hand-written latency, watchdog, reset-abort and statistics sequences.
module tb_sdram_port_scheduler;

   localparam logic [23:0] RD_ADDR = 24'h000123;
   localparam logic [23:0] W0_ADDR = 24'h0A0010;
   localparam logic [23:0] W1_ADDR = 24'h1B0020;
   localparam logic [15:0] W0_DATA = 16'h1111;
   localparam logic [15:0] W1_DATA = 16'h2222;

   typedef struct {
      logic        rd;
      logic        w0;
      logic        w1;
      int          n;
      logic [19:0] seq;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int   checks = 0;
   int   failures = 0;

   int          mem_lat = 2;
   bit          mem_hang = 1'b0;
   logic [15:0] mem_val = 16'h0000;
   int          mem_cnt = 0;

   logic [1:0]  prev_call = 2'b00;
   logic [1:0]  grant_q[$];
   logic [15:0] gdata_q[$];
   int          done_cnt[3] = '{0, 0, 0};

   vec_t vecs[7];

   sdram_port_scheduler_if #(.AW(24), .DW(16)) bus ();

   sdram_port_scheduler #(
      .STARVE_LIMIT(4),
      .TIMEOUT_CYC (1024),
      .AW          (24),
      .DW          (16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   // Base controller model: answers a held mem_call with a one-cycle mem_done after mem_lat cycles
   always @(negedge clk) begin
      if (rst) begin
         bus.mem_done  = 2'b00;
         bus.mem_rdata = 16'h0000;
         mem_cnt       = 0;
      end else if (bus.mem_done != 2'b00) begin
         bus.mem_done = 2'b00;
      end else if (bus.mem_call != 2'b00 && !mem_hang) begin
         mem_cnt++;
         if (mem_cnt >= mem_lat) begin
            bus.mem_done  = bus.mem_call;
            bus.mem_rdata = mem_val;
            mem_cnt       = 0;
         end
      end else begin
         mem_cnt = 0;
      end
   end

   // Monitor: logs each new grant (identified by call type and address) and counts done pulses
   always @(negedge clk) begin
      if (bus.rd_done) done_cnt[0]++;
      if (bus.w0_done) done_cnt[1]++;
      if (bus.w1_done) done_cnt[2]++;
      if (bus.mem_call != 2'b00 && prev_call == 2'b00) begin
         if (bus.mem_call == 2'b01)        grant_q.push_back(2'd0);
         else if (bus.mem_addr == W0_ADDR) grant_q.push_back(2'd1);
         else if (bus.mem_addr == W1_ADDR) grant_q.push_back(2'd2);
         else                              grant_q.push_back(2'd3);
         gdata_q.push_back(bus.mem_wdata);
      end
      prev_call = bus.mem_call;
   end

   // Safety net so the run always ends
   initial begin
      #400000;
      $display("[TB] FAIL global_timeout: simulation still running at %0t, required finish", $time);
      $fatal(1, "[TB] global timeout");
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic applyStimulus(input logic rd, input logic w0, input logic w1);
      bus.rd_req = rd;
      bus.w0_req = w0;
      bus.w1_req = w1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic waitSignal(input int which, input int bound, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < bound && !seen; i++) begin
         tick();
         case (which)
            0:       seen = bus.rd_done;
            1:       seen = bus.w0_done;
            2:       seen = bus.w1_done;
            3:       seen = (bus.mem_call != 2'b00);
            default: seen = !bus.busy;
         endcase
      end
   endtask

   task automatic doReset();
      rst = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0);
      mem_hang = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic doAccess(input int id);
      bit seen;
      applyStimulus(id == 0, id == 1, id == 2);
      waitSignal(id, 40, seen);
      checkOutput($sformatf("stats_access_done_id%0d", id), 32'(seen), 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      tick();
   endtask

   initial begin
      bit   seen;
      int   base;
      int   dbase[3];
      int   exp_cnt[3];
      int   cyc;
      int   viol;
      logic [1:0] exp_id;

      vecs[0] = '{1'b1, 1'b0, 1'b0, 3,  20'h00000};
      vecs[1] = '{1'b1, 1'b1, 1'b1, 10, 20'h80100};
      vecs[2] = '{1'b0, 1'b1, 1'b1, 4,  20'h00099};
      vecs[3] = '{1'b0, 1'b0, 1'b1, 3,  20'h0002A};
      vecs[4] = '{1'b1, 1'b0, 1'b1, 10, 20'h80200};
      vecs[5] = '{1'b0, 1'b1, 1'b0, 3,  20'h00015};
      vecs[6] = '{1'b1, 1'b1, 1'b0, 10, 20'h40100};

      bus.rd_addr = RD_ADDR;
      bus.w0_addr = W0_ADDR;
      bus.w1_addr = W1_ADDR;
      bus.w0_data = W0_DATA;
      bus.w1_data = W1_DATA;
      applyStimulus(1'b0, 1'b0, 1'b0);
      tick();
      tick();

      // Reset values
      checkOutput("reset_mem_call", 32'(bus.mem_call), 32'd0);
      checkOutput("reset_busy", 32'(bus.busy), 32'd0);
      checkOutput("reset_dones", 32'({bus.rd_done, bus.w0_done, bus.w1_done}), 32'd0);
      checkOutput("reset_err", 32'(bus.err_timeout), 32'd0);
      checkOutput("reset_rd_data", 32'(bus.rd_data), 32'd0);
      rst = 1'b0;
      tick();

      // Single read: call two cycles after request, done one cycle after mem_done
      mem_lat = 6;
      mem_val = 16'hBEEF;
      applyStimulus(1'b1, 1'b0, 1'b0);
      tick();
      checkOutput("rd_call_not_yet", 32'(bus.mem_call), 32'd0);
      checkOutput("rd_busy_in_grant", 32'(bus.busy), 32'd1);
      tick();
      checkOutput("rd_call_latency", 32'(bus.mem_call), 32'd1);
      checkOutput("rd_mem_addr", 32'(bus.mem_addr), 32'(RD_ADDR));
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         tick();
         if (bus.mem_done != 2'b00) begin
            seen = 1'b1;
            checkOutput("rd_done_after_mem_done", 32'(bus.rd_done), 32'd1);
            checkOutput("rd_data_value", 32'(bus.rd_data), 32'hBEEF);
            checkOutput("rd_call_dropped", 32'(bus.mem_call), 32'd0);
         end else begin
            checkOutput("rd_done_early", 32'(bus.rd_done), 32'd0);
         end
      end
      checkOutput("rd_mem_done_seen", 32'(seen), 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      tick();
      checkOutput("rd_done_single_pulse", 32'(bus.rd_done), 32'd0);
      checkOutput("rd_busy_after", 32'(bus.busy), 32'd0);
      checkOutput("rd_data_held", 32'(bus.rd_data), 32'hBEEF);

      // Arbitration order table
      mem_lat = 2;
      for (int v = 0; v < 7; v++) begin
         doReset();
         base = grant_q.size();
         for (int k = 0; k < 3; k++) begin
            dbase[k]   = done_cnt[k];
            exp_cnt[k] = 0;
         end
         applyStimulus(vecs[v].rd, vecs[v].w0, vecs[v].w1);
         for (int i = 0; i < 400 && (grant_q.size() - base) < vecs[v].n; i++) begin
            tick();
         end
         applyStimulus(1'b0, 1'b0, 1'b0);
         waitSignal(4, 50, seen);
         checkOutput($sformatf("vec%0d_grants_reached", v), 32'((grant_q.size() - base) >= vecs[v].n), 32'd1);
         for (int i = 0; i < vecs[v].n; i++) begin
            exp_id = vecs[v].seq[2*i +: 2];
            exp_cnt[exp_id]++;
            if (base + i < grant_q.size()) begin
               checkOutput($sformatf("vec%0d_grant%0d", v, i), 32'(grant_q[base + i]), 32'(exp_id));
               if (exp_id == 2'd1) begin
                  checkOutput($sformatf("vec%0d_wdata%0d", v, i), 32'(gdata_q[base + i]), 32'(W0_DATA));
               end else if (exp_id == 2'd2) begin
                  checkOutput($sformatf("vec%0d_wdata%0d", v, i), 32'(gdata_q[base + i]), 32'(W1_DATA));
               end
            end
         end
         for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("vec%0d_done_count_id%0d", v, k), 32'(done_cnt[k] - dbase[k]), 32'(exp_cnt[k]));
         end
      end

      // Watchdog: controller never answers a W0 write
      doReset();
      dbase[1] = done_cnt[1];
      mem_hang = 1'b1;
      applyStimulus(1'b0, 1'b1, 1'b0);
      waitSignal(3, 10, seen);
      checkOutput("to_w0_call", 32'(bus.mem_call), 32'd2);
      cyc = 0;
      while (!bus.err_timeout && cyc < 1100) begin
         tick();
         cyc++;
      end
      checkOutput("to_cycles_in_wait", 32'(cyc), 32'd1024);
      checkOutput("to_err_set", 32'(bus.err_timeout), 32'd1);
      checkOutput("to_call_dropped", 32'(bus.mem_call), 32'd0);
      mem_hang = 1'b0;
      mem_val  = 16'h5A5A;
      base = grant_q.size();
      applyStimulus(1'b1, 1'b1, 1'b0);
      tick();
      checkOutput("to_no_w0_done", 32'(done_cnt[1] - dbase[1]), 32'd0);
      waitSignal(0, 30, seen);
      checkOutput("to_rd_served", 32'(seen), 32'd1);
      checkOutput("to_rd_data", 32'(bus.rd_data), 32'h5A5A);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("to_next_grant_rd", 32'(grant_q.size() > base ? grant_q[base] : 2'd3), 32'd0);
      viol = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (bus.mem_call != 2'b00) viol++;
      end
      checkOutput("to_w0_blocked_while_held", 32'(viol), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b1, 1'b0);
      waitSignal(3, 10, seen);
      checkOutput("to_w0_unblocked_call", 32'(bus.mem_call), 32'd2);
      waitSignal(1, 30, seen);
      checkOutput("to_w0_done_after_unblock", 32'(seen), 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      tick();
      checkOutput("to_err_sticky", 32'(bus.err_timeout), 32'd1);

      // Reset two cycles into a W1 write
      doReset();
      mem_lat = 50;
      dbase[2] = done_cnt[2];
      applyStimulus(1'b0, 1'b0, 1'b1);
      waitSignal(3, 10, seen);
      checkOutput("rst_w1_call", 32'(bus.mem_call), 32'd2);
      tick();
      tick();
      applyStimulus(1'b1, 1'b1, 1'b1);
      rst = 1'b1;
      #1;
      checkOutput("rst_call_dropped_async", 32'(bus.mem_call), 32'd0);
      checkOutput("rst_busy_cleared", 32'(bus.busy), 32'd0);
      checkOutput("rst_err_cleared", 32'(bus.err_timeout), 32'd0);
      tick();
      rst = 1'b0;
      mem_lat = 2;
      waitSignal(3, 10, seen);
      checkOutput("rst_first_grant_rd", 32'(bus.mem_call), 32'd1);
      checkOutput("rst_no_w1_done", 32'(done_cnt[2] - dbase[2]), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      waitSignal(4, 50, seen);

      // Statistics: 5 reads and 3 W1 writes
      doReset();
      for (int i = 0; i < 5; i++) doAccess(0);
      for (int i = 0; i < 3; i++) doAccess(2);
      tick();
`ifdef SDRAM_SCHED_STATS_EN
      checkOutput("stat_rd", bus.stat_rd, 32'd5);
      checkOutput("stat_w0", bus.stat_w0, 32'd0);
      checkOutput("stat_w1", bus.stat_w1, 32'd3);
      checkOutput("stat_timeouts", 32'(bus.stat_timeouts), 32'd0);
`else
      checkOutput("stat_rd_tied", bus.stat_rd, 32'd0);
      checkOutput("stat_w0_tied", bus.stat_w0, 32'd0);
      checkOutput("stat_w1_tied", bus.stat_w1, 32'd0);
      checkOutput("stat_timeouts_tied", 32'(bus.stat_timeouts), 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sdram_port_scheduler.md
Name: sdram_port_scheduler

Overview:
Shares the single-port SDRAM base controller (iCall/oDone level-request/done-pulse interface) between three requesters: the TFT refresh reader (RD), the draw writer (W0) and the pulse-counter log writer (W1). RD has fixed priority, bounded by a write-starvation limit; W0 and W1 are served round-robin. Sits between the requester adapters and the SDRAM base controller, in the 133 MHz domain, replacing the two-port read/write arbitration.

Parameters:
STARVE_LIMIT, 4, consecutive RD grants allowed while any write is pending (1..15)
TIMEOUT_CYC, 1024, cycles in WAIT_DONE before the watchdog aborts the access
AW, 24, address width: bank(2)+row(13)+column(9)
DW, 16, data width

Ports:
clk  in  1  133 MHz system clock (210-degree PLL phase)
rst  in  1  asynchronous reset, active-high
rd_req  in  1  RD level request; held until rd_done
rd_addr  in  AW  RD address, stable while rd_req=1
rd_done  out  1  one-cycle pulse, read complete
rd_data  out  DW  read data, valid when rd_done=1 and held until the next read completes
w0_req / w1_req  in  1  write level requests
w0_addr / w1_addr  in  AW  write addresses
w0_data / w1_data  in  DW  write data
w0_done / w1_done  out  1  one-cycle write-complete pulses
mem_call  out  2  to base controller: [1]=write, [0]=read
mem_addr  out  AW  to base controller
mem_wdata  out  DW  to base controller
mem_done  in  2  from base controller: [1]=write done, [0]=read done
mem_rdata  in  DW  from base controller
busy  out  1  high in every state except IDLE
err_timeout  out  1  sticky watchdog flag; cleared only by rst

Behaviour:
- Reset: all outputs 0, state IDLE, round-robin pointer = W0, starvation count 0. Reset during an access drops mem_call immediately (asynchronous). No done pulse is issued for the aborted access.
- States: IDLE -> GRANT -> WAIT_DONE -> RELEASE -> IDLE.
- IDLE: sample the requests. Selection rule:
  - If a write is pending and the starvation count equals STARVE_LIMIT, select a write.
  - Otherwise, if rd_req=1, select RD.
  - Otherwise select a write.
  - When both writes are pending, choose the one at the round-robin pointer. After each write grant, the pointer moves to the other writer.
  - With no request pending, remain in IDLE.
- Starvation count:
  - Increments on each RD grant made while w0_req or w1_req is high, saturating at STARVE_LIMIT.
  - Clears on any write grant.
  - Clears on an RD grant made with no write pending.
- GRANT, one cycle:
  - Latch the winner's address, data and ID into registers.
  - Drive mem_addr/mem_wdata from those registers.
  - Assert mem_call: 2'b10 for a write, 2'b01 for a read.
- WAIT_DONE:
  - Hold mem_call and mem_addr/mem_wdata stable.
  - On the matching mem_done bit: deassert mem_call, latch mem_rdata into rd_data (read only), and go to RELEASE.
  - A mem_done bit that does not match the granted access is ignored.
- RELEASE, one cycle:
  - mem_call=0, so the base controller sees the request dropped.
  - Pulse the granted requester's done for this cycle.
  - Go to IDLE.
- Latency: mem_call rises 2 cycles after the request is seen in IDLE. The requester's done pulse comes 1 cycle after mem_done.
- Requester rules:
  - A requester must deassert req on the cycle after its done pulse.
  - If req is dropped mid-access, the access still completes and done still pulses.
  - The back-to-back minimum is 4 cycles per access.
- Watchdog:
  - Counts cycles in WAIT_DONE. At TIMEOUT_CYC it sets err_timeout, drops mem_call and enters RELEASE without a done pulse.
  - The requester's req is then ignored until it drops for at least one cycle.
- Simultaneous rd_req, w0_req and w1_req with count < STARVE_LIMIT: RD wins, deterministically.
- Widths: the counters are unsigned. The watchdog counter is clog2(TIMEOUT_CYC+1) bits and never wraps.

Optional Feature:
SDRAM_SCHED_STATS_EN
- Defined: adds outputs stat_rd, stat_w0, stat_w1 (32 bits each), saturating at 32'hFFFFFFFF. Each increments on the RELEASE cycle of a completed access by that requester. A fourth output, stat_timeouts (16 bits, saturating), counts watchdog aborts. All clear on rst.
- Undefined: these ports are still present but tied to 0, and no counter logic is generated.

Decomposition:
- Shared package sdram_sched_pkg:
  - state enum: IDLE, GRANT, WAIT_DONE, RELEASE
  - requester ID enum: RD, W0, W1
  - mem_call encodings: CALL_WR=2'b10, CALL_RD=2'b01, CALL_NONE=2'b00
  - default AW/DW
- One natural sub-module, sdram_sched_select: the combinational winner selection plus the registered round-robin pointer and starvation counter. The top level keeps the FSM, watchdog and datapath registers.

Test Plan:
- Single RD at 24'h000123, with the base controller model returning 16'hBEEF after 6 cycles -> mem_call=01 two cycles after rd_req; rd_done pulses one cycle after mem_done with rd_data=16'hBEEF; busy low afterwards.
- rd_req, w0_req and w1_req all asserted at once and kept asserted -> with STARVE_LIMIT=4, grant order RD,RD,RD,RD,W0,RD,RD,RD,RD,W1.
- Only W0 and W1 pending, both continuous -> grants alternate W0,W1,W0,W1; mem_wdata matches each writer's data; exactly one done pulse per access.
- Base controller model never returns mem_done -> after 1024 cycles err_timeout=1, mem_call=0, no w0_done; the next request from a different requester is served normally.
- rst asserted 2 cycles into WAIT_DONE of a write -> mem_call=0 within the same cycle; no done pulse; after release, the first grant goes to the highest-priority pending request.
- With SDRAM_SCHED_STATS_EN defined, run 5 RD and 3 W1 accesses -> stat_rd=5, stat_w1=3, stat_w0=0; without the macro all stat_* outputs read 0.
